// File: rtl/mux_64bit_sel.sv
// -----------------------------------------------------------------------------
// mux_64bit_sel
// 64-bit two-input word selector: out = s ? b : a, built from 64 one-bit mux
// cells that share the select line.
//
// Configuration macro: MUX64_OUT_REG_EN
//   undefined (default) : purely combinational, zero latency, clk/rst unused.
//   defined             : mux result registered in out_q, one-cycle latency,
//                         asynchronous active-high reset clears out_q to 0.
//
// Port order (out, s, a, b, clk, rst) keeps existing four-port positional
// instantiations (out, s, a, b) valid in combinational builds.
// -----------------------------------------------------------------------------

// One-bit 2:1 mux cell: y = (~s & a) | (s & b).
// The extra a & b consensus term does not change the function for a known
// select, but makes a bit resolve to the common value of a and b when s is
// X/Z (plain AND-OR logic would turn a==b==1 into X).
module mux2_cell (
    output logic y,
    input  logic s,
    input  logic a,
    input  logic b
);

    logic s_n;
    logic pick_a;
    logic pick_b;
    logic agree;

    assign s_n    = ~s;
    assign pick_a = s_n & a;
    assign pick_b = s & b;
    assign agree  = a & b;
    assign y      = pick_a | pick_b | agree;

endmodule

module mux_64bit_sel (
    output logic [63:0] out,
    input  logic        s,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        clk,
    input  logic        rst
);

    // Bitwise selection result; bit i depends only on s, a[i], b[i].
    logic [63:0] mux_w;

    // One mux cell per bit, all driven by the shared select.
    for (genvar i = 0; i < 64; i++) begin : g_bit
        mux2_cell u_cell (
            .y (mux_w[i]),
            .s (s),
            .a (a[i]),
            .b (b[i])
        );
    end

`ifdef MUX64_OUT_REG_EN

    logic [63:0] out_q;

    // Output register: captures the selection on each rising edge, cleared
    // immediately by rst and held at zero while rst is high.
    // NOTE: the reset is in the sensitivity list, so rst acts without a clock
    // edge; non-blocking assignment keeps every bit updating from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= mux_w;
        end
    end

    assign out = out_q;

`else

    // Combinational build: clk and rst are intentionally left unused.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign out = mux_w;

`endif

endmodule

// File: tb/tb_mux_64bit_sel.sv
// -----------------------------------------------------------------------------
// tb_mux_64bit_sel
// Self-checking bench for mux_64bit_sel. Follows MUX64_OUT_REG_EN: the
// combinational build is checked after a 20-unit hold, the registered build
// one rising edge after the inputs are applied, plus reset sequences.
// -----------------------------------------------------------------------------
module tb_mux_64bit_sel;

    logic [63:0] out;
    logic        s;
    logic [63:0] a;
    logic [63:0] b;
    logic        clk;
    logic        rst;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] PAT_A = 64'h9000_000A_9000_000A;
    localparam logic [63:0] PAT_B = 64'h1000_001E_1000_001E;

    typedef struct {
        string       name;
        logic        s;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    mux_64bit_sel dut (
        .out (out),
        .s   (s),
        .a   (a),
        .b   (b),
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Select is X: each bit must be the common value where a[i]==b[i] and X
    // elsewhere. A two-state simulator resolves s to 0 or 1, so a clean
    // selection of a or b is accepted there.
    task automatic check_sel_x(input string name, input logic [63:0] va,
                               input logic [63:0] vb);
        logic [63:0] exp4;
        for (int i = 0; i < 64; i++)
            exp4[i] = (va[i] === vb[i]) ? va[i] : 1'bx;
        checks++;
        if (!(out === exp4 || out === va || out === vb)) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (or a/b)", name, out, exp4);
        end
    endtask

    initial begin
        logic [63:0] one;

        s   = 1'b0;
        a   = '0;
        b   = '0;
        rst = 1'b0;

        // Directed patterns.
        vecs.push_back('{"plan_s0",   1'b0, PAT_A, PAT_B, PAT_A});
        vecs.push_back('{"plan_s1",   1'b1, PAT_A, PAT_B, PAT_B});
        vecs.push_back('{"ones_s0",   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                         64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{"ones_s1",   1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                         64'h0});
        vecs.push_back('{"alt_s0",    1'b0, 64'hAAAA_AAAA_AAAA_AAAA,
                         64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA});
        vecs.push_back('{"alt_s1",    1'b1, 64'hAAAA_AAAA_AAAA_AAAA,
                         64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555});
        vecs.push_back('{"msb_b_s1",  1'b1, 64'h0, 64'h8000_0000_0000_0001,
                         64'h8000_0000_0000_0001});
        // Walking one on a, b = 0, s toggling: out = a when s=0, 0 when s=1.
        for (int i = 0; i < 64; i++) begin
            one = 64'h1 << i;
            vecs.push_back('{$sformatf("walk%0d", i), 1'(i % 2), one, 64'h0,
                             ((i % 2) == 0) ? one : 64'h0});
        end

`ifndef MUX64_OUT_REG_EN
        // ---------------- combinational build ----------------
        #1;
        for (int k = 0; k < vecs.size(); k++) begin
            s = vecs[k].s;
            a = vecs[k].a;
            b = vecs[k].b;
            #20;
            check(vecs[k].name, out, vecs[k].exp);
        end

        // clk/rst have no effect on the combinational path.
        s = 1'b1; a = PAT_A; b = PAT_B; rst = 1'b1;
        #20;
        check("rst_ignored", out, PAT_B);
        rst = 1'b0;

        // Undetermined select.
        s = 1'bx; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h0;
        #20;
        check_sel_x("s_x_differ", a, b);
        a = 64'h5555_5555_5555_5555; b = 64'h5555_5555_5555_5555;
        #20;
        check_sel_x("s_x_agree", a, b);
        check("s_x_agree_val", out, 64'h5555_5555_5555_5555);
`else
        // ---------------- registered build ----------------
        // Load a nonzero value, then reset without a clock edge.
        @(negedge clk);
        s = 1'b0; a = PAT_A; b = PAT_B;
        @(posedge clk); #1;
        check("pre_rst_load", out, PAT_A);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_async", out, 64'h0);

        // Edges are ignored while reset is held.
        s = 1'b1;
        @(posedge clk); #1;
        check("rst_hold_edge", out, 64'h0);

        // Release: out stays 0 until the first edge, then shows b.
        @(negedge clk);
        rst = 1'b0; s = 1'b1; b = PAT_B;
        #1;
        check("release_pre_edge", out, 64'h0);
        @(posedge clk); #1;
        check("release_first_edge", out, PAT_B);

        // Reset mid-cycle while out != 0 discards the pending value.
        @(negedge clk);
        s = 1'b0; a = 64'hDEAD_BEEF_0123_4567;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_cycle", out, 64'h0);
        @(negedge clk);
        rst = 1'b0; s = 1'b0; a = PAT_A;
        @(posedge clk); #1;
        check("after_mid_rst", out, PAT_A);

        // Select and data both change shortly before the edge.
        @(negedge clk);
        s = 1'b0; a = 64'h1111_1111_1111_1111; b = 64'h2222_2222_2222_2222;
        #4;
        s = 1'b1; b = 64'h3333_3333_3333_3333;
        @(posedge clk); #1;
        check("late_change", out, 64'h3333_3333_3333_3333);

        // One-cycle latency: a vector applied after an edge is not visible yet.
        @(negedge clk);
        s = 1'b0; a = 64'h0F0F_0F0F_0F0F_0F0F;
        #1;
        check("latency_hold", out, 64'h3333_3333_3333_3333);

        // Table vectors, each checked one edge after it is applied.
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            s = vecs[k].s;
            a = vecs[k].a;
            b = vecs[k].b;
            @(posedge clk); #1;
            check(vecs[k].name, out, vecs[k].exp);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
